// File: rtl/sawtooth_monitor.sv
// Bus-mapped monitor for an 8-bit stepped waveform: classifies each input change as step, wrap or glitch,
// and reports the recovered step period plus step/wrap counts and sticky status flags.
module sawtooth_monitor #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  in
);

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, MEAS = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               en;
  logic [7:0]         prev;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period;
  logic [15:0]        steps, wraps;
  logic               lock, glitch, ovf;

  logic               chg, ev_step, ev_wrap, ev_glitch, sat;
  logic               wr_ctrl, clr, en_next;
  logic               upd_period, set_lock, clr_lock, set_glitch, set_ovf, cnt_step, cnt_wrap;
  logic [31:0]        period_ext, rd_val;
  logic               unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:2], wstrb[3:1]};

  assign chg       = (in != prev);
  assign ev_wrap   = chg && (prev == 8'hFF) && (in == 8'h00);
  assign ev_step   = chg && (prev != 8'hFF) && (in == prev + 8'd1);
  assign ev_glitch = chg && !ev_step && !ev_wrap;
  assign sat       = !chg && (&cnt);

  // CTRL lives entirely in byte 0; CLR is a one-cycle pulse that is never stored.
  assign wr_ctrl = valid && wstrb[0] && (addr[3:2] == 2'd0);
  assign clr     = wr_ctrl && wdata[1];
  assign en_next = wr_ctrl ? wdata[0] : en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A clear overrides event handling in the same cycle; otherwise EN=0 forces IDLE.
  always_comb begin
    state_d    = state_q;
    upd_period = 1'b0;
    set_lock   = 1'b0;
    clr_lock   = 1'b0;
    set_glitch = 1'b0;
    set_ovf    = 1'b0;
    cnt_step   = 1'b0;
    cnt_wrap   = 1'b0;
    if (clr) begin
      state_d = en_next ? SYNC : IDLE;
    end else if (!en) begin
      state_d  = IDLE;
      clr_lock = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (ev_step || ev_wrap) begin
            state_d  = MEAS;
            cnt_step = ev_step;
            cnt_wrap = ev_wrap;
          end else if (ev_glitch) begin
            set_glitch = 1'b1;
          end else if (sat) begin
            set_ovf = 1'b1;
          end
        end
        MEAS: begin
          if (ev_step || ev_wrap) begin
            upd_period = 1'b1;
            set_lock   = 1'b1;
            cnt_step   = ev_step;
            cnt_wrap   = ev_wrap;
          end else if (ev_glitch) begin
            set_glitch = 1'b1;
            clr_lock   = 1'b1;
            state_d    = SYNC;
          end else if (sat) begin
            set_ovf  = 1'b1;
            clr_lock = 1'b1;
            state_d  = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en     <= 1'b0;
      prev   <= 8'd0;
      cnt    <= '0;
      period <= '0;
      steps  <= 16'd0;
      wraps  <= 16'd0;
      lock   <= 1'b0;
      glitch <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      en   <= en_next;
      prev <= in;
      if (clr || !en || state_q == IDLE || chg) cnt <= '0;
      else if (!(&cnt))                         cnt <= cnt + CNT_W'(1);
      if (clr) begin
        period <= '0;
        steps  <= 16'd0;
        wraps  <= 16'd0;
        lock   <= 1'b0;
        glitch <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (upd_period) period <= cnt;
        if (set_lock)      lock <= 1'b1;
        else if (clr_lock) lock <= 1'b0;
        if (set_glitch) glitch <= 1'b1;
        if (set_ovf)    ovf    <= 1'b1;
        steps <= steps + 16'(cnt_step);
        wraps <= wraps + 16'(cnt_wrap);
      end
    end
  end

  always_comb begin
    period_ext              = 32'd0;
    period_ext[CNT_W-1:0]   = period;
  end

  always_comb begin
    rd_val = 32'd0;
    case (addr[3:2])
      2'd0: rd_val = {31'd0, en};
      2'd1: rd_val = period_ext;
      2'd2: rd_val = {wraps, steps};
      2'd3: rd_val = {29'd0, ovf, glitch, lock};
      default: rd_val = 32'd0;
    endcase
  end

  // Every request is acknowledged one cycle later; read data is captured in the request cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= valid;
      if (valid) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_sawtooth_monitor.sv
// Directed bench for sawtooth_monitor: bus driver tasks push expected read data into a queue,
// and a monitor pops and compares whenever the DUT acknowledges.
module tb_sawtooth_monitor;
  localparam int CNT_W = 8;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  in;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          rd_q[$];
  bit          is_rd;

  sawtooth_monitor #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .wstrb  (wstrb),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .in     (in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit rd, input logic [31:0] e, input string nm);
    @(negedge clk);
    valid = 1'b1;
    addr  = {28'd0, a, 2'b00};
    wstrb = s;
    wdata = d;
    rd_q.push_back(rd);
    if (rd) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(negedge clk);
    valid = 1'b0;
    wstrb = 4'd0;
    check({nm, " ready"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus(a, 4'd0, 32'd0, 1'b1, e, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(a, s, d, 1'b0, 32'd0, "wr");
  endtask

  // Value v is visible to the DUT for n rising edges.
  task automatic hold(input logic [7:0] v, input int n);
    @(negedge clk);
    in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (resetn && ready) begin
      if (rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_ready: got ready=1 expected no pending request");
      end else begin
        is_rd = rd_q.pop_front();
        if (is_rd) check(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    valid  = 1'b0;
    wstrb  = 4'd0;
    addr   = 32'd0;
    wdata  = 32'd0;
    in     = 8'd0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    resetn = 1'b1;
    rd(2'd0, 32'd0, "rst ctrl");
    rd(2'd1, 32'd0, "rst period");
    rd(2'd2, 32'd0, "rst count");
    rd(2'd3, 32'd0, "rst status");

    // Steps every 4 clocks.
    wr(2'd0, 4'h1, 32'h1);
    hold(8'd1, 4);
    hold(8'd2, 4);
    hold(8'd3, 4);
    rd(2'd1, 32'd3, "t1 period");
    rd(2'd2, 32'd3, "t1 count");
    rd(2'd3, 32'd1, "t1 status");

    // Value 3 held 10 edges because of the reads, then regular steps, then a 5->9 jump.
    hold(8'd4, 4);
    hold(8'd5, 4);
    hold(8'd9, 4);
    rd(2'd1, 32'd3, "t3 period hold");
    rd(2'd2, 32'd5, "t3 count");
    rd(2'd3, 32'd2, "t3 status glitch");
    hold(8'd10, 4);
    hold(8'd11, 4);
    rd(2'd1, 32'd3, "t3 period relock");
    rd(2'd2, 32'd7, "t3 count relock");
    rd(2'd3, 32'd3, "t3 status relock");

    // Ramp through the wrap at 2 clocks per step; 11->FD is a glitch first.
    hold(8'hFD, 2);
    hold(8'hFE, 2);
    hold(8'hFF, 2);
    hold(8'h00, 2);
    hold(8'h01, 2);
    rd(2'd1, 32'd1, "t2 period");
    rd(2'd2, 32'h0001_000A, "t2 count");
    rd(2'd3, 32'd3, "t2 status");

    // Constant input long enough to saturate the 8-bit counter.
    repeat (300) @(negedge clk);
    rd(2'd1, 32'd1, "t4 period");
    rd(2'd2, 32'h0001_000A, "t4 count");
    rd(2'd3, 32'd6, "t4 status ovf");
    hold(8'd2, 4);
    hold(8'd3, 4);
    rd(2'd3, 32'd7, "t4 status relock");
    rd(2'd2, 32'h0001_000C, "t4 count relock");

    // Clear while measuring, input held so nothing new is counted.
    wr(2'd0, 4'h1, 32'h3);
    rd(2'd1, 32'd0, "t5 period");
    rd(2'd2, 32'd0, "t5 count");
    rd(2'd3, 32'd0, "t5 status");
    rd(2'd0, 32'd1, "t5 ctrl");

    // Relock, read, then asynchronous reset while ready/rdata are live.
    hold(8'd4, 4);
    hold(8'd5, 4);
    rd(2'd1, 32'd3, "t6 period");
    #2 resetn = 1'b0;
    #1;
    check("t6 async ready", {31'd0, ready}, 32'd0);
    check("t6 async rdata", rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    rd(2'd0, 32'd0, "t6 ctrl");
    rd(2'd1, 32'd0, "t6 period");
    rd(2'd2, 32'd0, "t6 count");
    rd(2'd3, 32'd0, "t6 status");

    // Byte strobes and read-only registers; disabled monitor counts nothing.
    wr(2'd0, 4'b0010, 32'h1);
    rd(2'd0, 32'd0, "strobe ctrl");
    wr(2'd1, 4'hF, 32'hFF);
    rd(2'd1, 32'd0, "ro period");
    hold(8'd6, 4);
    hold(8'd7, 4);
    rd(2'd2, 32'd0, "idle count");
    rd(2'd3, 32'd0, "idle status");

    repeat (3) @(negedge clk);
    check("pending requests", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
